// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: CAN TX mailbox arbiter and frame scheduler
// Picks the requesting mailbox with the lowest identifier (ties go to the lowest
// index), requests SOF, follows the frame to completion, then acks or retries it
// and waits out intermission before the next arbitration.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   enable              scheduler enable (ignored once a frame is committed)
//   mb_req, mb_id       per-mailbox level request and packed identifiers
//   bus_idle            gates the start of arbitration
//   sample_point        one pulse per bit time, counted during intermission
//   sof_transmitting    SOF generator is driving SOF (frame committed)
//   sof_complete        SOF bit finished, frame body follows
//   frame_done, arb_lost, tx_error   frame outcome pulses
//   Tx_request          request to the SOF generator
//   sel_id, sel_idx     latched winner
//   mb_ack, mb_fail     one-cycle per-mailbox outcome pulses
//   busy                scheduler is not idle
// Optional feature: define CAN_RETRY_LIMIT_EN to fail a mailbox after MAX_RETRIES tx_errors.
module can_tx_scheduler #(
    parameter int NUM_MB            = 4,
    parameter int ID_W              = 11,
    parameter int INTERMISSION_BITS = 3,
    parameter int MAX_RETRIES       = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_MB-1:0]         mb_req,
    input  logic [NUM_MB*ID_W-1:0]    mb_id,
    input  logic                      bus_idle,
    input  logic                      sample_point,
    input  logic                      sof_transmitting,
    input  logic                      sof_complete,
    input  logic                      frame_done,
    input  logic                      arb_lost,
    input  logic                      tx_error,
    output logic                      Tx_request,
    output logic [ID_W-1:0]           sel_id,
    output logic [$clog2(NUM_MB)-1:0] sel_idx,
    output logic [NUM_MB-1:0]         mb_ack,
    output logic [NUM_MB-1:0]         mb_fail,
    output logic                      busy
);
    localparam int IDX_W = $clog2(NUM_MB);
    localparam int RC_W  = $clog2(MAX_RETRIES + 1);
    localparam int CW    = $clog2(INTERMISSION_BITS + 1);

    typedef enum logic [2:0] {IDLE, SELECT, WAIT_SOF, IN_FRAME, INTERMISSION} state_t;
    state_t state, state_n;

    logic [IDX_W-1:0] best_idx;
    logic [ID_W-1:0]  best_id;
    logic             best_vld;
    logic [RC_W-1:0]  retry_cnt, retry_next;
    logic [CW-1:0]    bit_cnt;
    logic             ev_err, ev_arb, ev_done, ev_fail, int_last;

    // Strict less-than keeps the earlier (lower) index on equal identifiers.
    always_comb begin
        best_idx = '0;
        best_id  = '0;
        best_vld = 1'b0;
        for (int i = 0; i < NUM_MB; i++)
            if (mb_req[i] && (!best_vld || mb_id[i*ID_W +: ID_W] < best_id)) begin
                best_vld = 1'b1;
                best_idx = IDX_W'(i);
                best_id  = mb_id[i*ID_W +: ID_W];
            end
    end

    // Outcome priority: tx_error over arb_lost over frame_done.
    assign ev_err     = (state == IN_FRAME) && tx_error;
    assign ev_arb     = (state == IN_FRAME) && arb_lost && !tx_error;
    assign ev_done    = (state == IN_FRAME) && frame_done && !tx_error && !arb_lost;
    assign retry_next = retry_cnt + 1'b1;
    assign int_last   = (state == INTERMISSION) && sample_point && (bit_cnt == CW'(INTERMISSION_BITS - 1));
`ifdef CAN_RETRY_LIMIT_EN
    assign ev_fail = ev_err && (retry_next == RC_W'(MAX_RETRIES));
`else
    assign ev_fail = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:         if (enable && |mb_req && bus_idle) state_n = SELECT;
            SELECT:       state_n = best_vld ? WAIT_SOF : IDLE;
            // Abort is only possible before the SOF generator has committed.
            WAIT_SOF:     if (sof_complete) state_n = IN_FRAME;
                          else if (!sof_transmitting && (!enable || !mb_req[sel_idx])) state_n = IDLE;
            IN_FRAME:     if (ev_err || ev_arb || ev_done) state_n = INTERMISSION;
            INTERMISSION: if (int_last) state_n = IDLE;
            default:      state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock)
        state <= reset ? IDLE : state_n;

    assign Tx_request = (state == WAIT_SOF);
    assign busy       = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_idx   <= '0;
            sel_id    <= '0;
            retry_cnt <= '0;
            bit_cnt   <= '0;
            mb_ack    <= '0;
            mb_fail   <= '0;
        end else begin
            mb_ack  <= ev_done ? NUM_MB'(1) << sel_idx : '0;
            mb_fail <= ev_fail ? NUM_MB'(1) << sel_idx : '0;
            if (state == SELECT && best_vld) begin
                sel_idx <= best_idx;
                sel_id  <= best_id;
                if (best_idx != sel_idx) retry_cnt <= '0;
            end
            if (ev_done || ev_fail) retry_cnt <= '0;
            else if (ev_err) retry_cnt <= retry_next;
            if (state == INTERMISSION && sample_point) bit_cnt <= int_last ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb_can_tx_scheduler: self-checking bench for can_tx_scheduler
module tb_can_tx_scheduler;
    logic        clock = 1'b0, reset = 1'b1, enable = 1'b0, bus_idle = 1'b0, sample_point = 1'b0;
    logic        sof_transmitting = 1'b0, sof_complete = 1'b0, frame_done = 1'b0, arb_lost = 1'b0, tx_error = 1'b0;
    logic [3:0]  mb_req = '0;
    logic [43:0] mb_id = '0;
    logic        Tx_request, busy;
    logic [10:0] sel_id;
    logic [1:0]  sel_idx;
    logic [3:0]  mb_ack, mb_fail;
    int          n_vec = 0, n_err = 0;

    can_tx_scheduler dut (
        .clock(clock), .reset(reset), .enable(enable), .mb_req(mb_req), .mb_id(mb_id),
        .bus_idle(bus_idle), .sample_point(sample_point), .sof_transmitting(sof_transmitting),
        .sof_complete(sof_complete), .frame_done(frame_done), .arb_lost(arb_lost), .tx_error(tx_error),
        .Tx_request(Tx_request), .sel_id(sel_id), .sel_idx(sel_idx), .mb_ack(mb_ack),
        .mb_fail(mb_fail), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  req;
        logic [43:0] ids;
        logic [1:0]  eidx;
        logic [10:0] eid;
    } vec_t;
    vec_t vt[7];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // IDLE -> SELECT -> WAIT_SOF with the request already held.
    task automatic arb(input logic [3:0] req);
        mb_req = req;
        tick();
        chk("tx_req_select", Tx_request, 0);
        chk("busy_select", busy, 1);
        tick();
        chk("tx_req_wait_sof", Tx_request, 1);
    endtask

    task automatic sof();
        sof_transmitting = 1'b1;
        sof_complete = 1'b1;
        tick();
        sof_transmitting = 1'b0;
        sof_complete = 1'b0;
        chk("tx_req_in_frame", Tx_request, 0);
    endtask

    task automatic inter();
        for (int p = 1; p <= 3; p++) begin
            sample_point = 1'b1;
            tick();
            sample_point = 1'b0;
            chk($sformatf("busy_inter%0d", p), busy, p < 3);
            if (p < 3) tick();
        end
    endtask

    initial begin
        int          keys[$];
        int          last_idx, rcnt, o;
        logic [3:0]  req, exp_ack, exp_fail;
        logic [1:0]  eidx;
        logic [10:0] eid;

        vt[0] = '{4'b0110, {11'h000, 11'h0A5, 11'h123, 11'h000}, 2'd2, 11'h0A5};
        vt[1] = '{4'b1001, {11'h200, 11'h000, 11'h000, 11'h200}, 2'd0, 11'h200};
        vt[2] = '{4'b1000, {11'h7FF, 11'h000, 11'h000, 11'h000}, 2'd3, 11'h7FF};
        vt[3] = '{4'b1111, {11'h001, 11'h002, 11'h003, 11'h004}, 2'd3, 11'h001};
        vt[4] = '{4'b1110, {11'h300, 11'h300, 11'h300, 11'h000}, 2'd1, 11'h300};
        vt[5] = '{4'b1111, {11'h000, 11'h000, 11'h000, 11'h000}, 2'd0, 11'h000};
        vt[6] = '{4'b0101, {11'h000, 11'h7FF, 11'h000, 11'h7FF}, 2'd0, 11'h7FF};

        // Reset state
        tick();
        chk("rst_tx_req", Tx_request, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel_idx", sel_idx, 0);
        chk("rst_sel_id", sel_id, 0);
        chk("rst_ack", mb_ack, 0);
        chk("rst_fail", mb_fail, 0);
        reset = 1'b0;
        enable = 1'b1;
        bus_idle = 1'b1;

        // Table: arbitration result, then abort by dropping the request before SOF
        for (int v = 0; v < 7; v++) begin
            mb_id = vt[v].ids;
            arb(vt[v].req);
            chk($sformatf("tbl%0d_idx", v), sel_idx, vt[v].eidx);
            chk($sformatf("tbl%0d_id", v), sel_id, vt[v].eid);
            mb_req = '0;
            tick();
            chk($sformatf("tbl%0d_abort_tx", v), Tx_request, 0);
            chk($sformatf("tbl%0d_abort_busy", v), busy, 0);
            chk($sformatf("tbl%0d_abort_ack", v), mb_ack, 0);
        end

        // T1 full frame, enable dropped mid-frame must not stop the ack
        mb_id = vt[0].ids;
        arb(4'b0110);
        chk("t1_idx", sel_idx, 2);
        sof();
        enable = 1'b0;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        mb_req = '0;
        chk("t1_ack", mb_ack, 4'b0100);
        tick();
        chk("t1_ack_pulse", mb_ack, 0);
        inter();
        enable = 1'b1;

        // T3 arbitration lost on mb2 while mb0 raises a higher-priority request
        mb_id = {11'h000, 11'h0A5, 11'h000, 11'h050};
        arb(4'b0100);
        chk("t3_idx_first", sel_idx, 2);
        sof();
        arb_lost = 1'b1;
        mb_req = 4'b0101;
        tick();
        arb_lost = 1'b0;
        chk("t3_no_ack", mb_ack, 0);
        inter();
        chk("t3_no_ack_late", mb_ack, 0);
        arb(4'b0101);
        chk("t3_idx_pre", sel_idx, 0);
        chk("t3_id_pre", sel_id, 11'h050);
        mb_req = '0;
        tick();
        chk("t3_abort_busy", busy, 0);

        // T5 reset mid-frame
        mb_id = {11'h000, 11'h000, 11'h000, 11'h0AA};
        arb(4'b0001);
        sof();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_tx", Tx_request, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_idx", sel_idx, 0);
        chk("t5_rst_id", sel_id, 0);
        chk("t5_rst_ack", mb_ack, 0);
        // T5 tx_error beats frame_done
        arb(4'b0001);
        sof();
        tx_error = 1'b1;
        frame_done = 1'b1;
        tick();
        tx_error = 1'b0;
        frame_done = 1'b0;
        mb_req = '0;
        chk("t5_err_no_ack", mb_ack, 0);
        chk("t5_err_busy", busy, 1);
        inter();

        // T6 eight tx_errors on mb1
        do_reset();
        mb_id = {11'h000, 11'h000, 11'h111, 11'h000};
        for (int r = 0; r < 8; r++) begin
            arb(4'b0010);
            sof();
            tx_error = 1'b1;
            tick();
            tx_error = 1'b0;
`ifdef CAN_RETRY_LIMIT_EN
            chk($sformatf("t6_fail%0d", r), mb_fail, (r == 7) ? 4'b0010 : 4'b0000);
`else
            chk($sformatf("t6_fail%0d", r), mb_fail, 0);
`endif
            chk($sformatf("t6_ack%0d", r), mb_ack, 0);
            if (r == 7) mb_req = '0;
            tick();
            chk($sformatf("t6_fail_pulse%0d", r), mb_fail, 0);
            inter();
        end
`ifndef CAN_RETRY_LIMIT_EN
        arb(4'b0010);
        chk("t6_ninth_idx", sel_idx, 1);
        mb_req = '0;
        tick();
`endif

        // Randomized transactions against a queue-sorted priority model
        do_reset();
        last_idx = 0;
        rcnt = 0;
        for (int t = 0; t < 40; t++) begin
            req = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) mb_id[i*11 +: 11] = 11'($urandom_range(0, 7) * 37);
            keys = {};
            for (int i = 0; i < 4; i++) if (req[i]) keys.push_back(int'(mb_id[i*11 +: 11]) * 4 + i);
            keys.sort();
            eidx = 2'(keys[0] % 4);
            eid = 11'(keys[0] / 4);
            arb(req);
            chk($sformatf("rnd%0d_idx", t), sel_idx, eidx);
            chk($sformatf("rnd%0d_id", t), sel_id, eid);
            if (int'(eidx) != last_idx) rcnt = 0;
            last_idx = int'(eidx);
            sof();
            o = $urandom_range(0, 3);
            frame_done = (o == 0 || o == 3);
            arb_lost = (o == 1);
            tx_error = (o >= 2);
            exp_ack = (o == 0) ? 4'b0001 << eidx : 4'b0000;
            exp_fail = '0;
            if (o == 0) rcnt = 0;
            if (o >= 2) begin
                rcnt++;
`ifdef CAN_RETRY_LIMIT_EN
                if (rcnt == 8) begin
                    exp_fail = 4'b0001 << eidx;
                    rcnt = 0;
                end
`endif
            end
            tick();
            frame_done = 1'b0;
            arb_lost = 1'b0;
            tx_error = 1'b0;
            mb_req = '0;
            chk($sformatf("rnd%0d_ack", t), mb_ack, exp_ack);
            chk($sformatf("rnd%0d_fail", t), mb_fail, exp_fail);
            tick();
            inter();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
